// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-domain pointer, full/almost_full, occupancy and overflow control of the async FIFO
module fifo_wr_ctrl #(
   parameter int WIDTH        = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_en,
   input  logic             ovf_clr,
   input  logic [WIDTH:0]   rptr_sync,
   output logic [WIDTH:0]   wptr,
   output logic [WIDTH-1:0] waddr,
   output logic             wr_accept,
   output logic             full,
   output logic             almost_full,
   output logic [WIDTH:0]   wr_count,
   output logic             overflow
);

   localparam logic [WIDTH:0] AF_T = AFULL_THRESH[WIDTH:0];

   logic [WIDTH:0] wbin_q,  wbin_d;
   logic [WIDTH:0] wptr_q,  wptr_d;
   logic           full_q,  full_d;
   logic           afull_q, afull_d;
   logic [WIDTH:0] count_q, count_d;
   logic           ovf_q,   ovf_d;

   logic [WIDTH:0] rbin;
   logic [WIDTH:0] full_target;
   logic [WIDTH:0] occ;
   logic           accept;

   // Writes are only taken when not full and never while reset is asserted.
   assign accept    = wr_en & ~full_q & rstn;
   assign wr_accept = accept;

   // Decode the synchronized Gray read pointer to binary (XOR of all bits at or above each position).
   always_comb begin
      rbin = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         rbin[i] = ^(rptr_sync >> i);
      end
   end

   // Next pointer, flags and occupancy; full is the Gray compare against the read pointer one lap behind.
   always_comb begin
      wbin_d      = wbin_q + {{WIDTH{1'b0}}, accept};
      wptr_d      = (wbin_d >> 1) ^ wbin_d;
      full_target = {~rptr_sync[WIDTH:WIDTH-1], rptr_sync[WIDTH-2:0]};
      full_d      = (wptr_d == full_target);
      occ         = wbin_d - rbin;
      count_d     = occ;
      afull_d     = (occ >= AF_T);
      ovf_d       = ovf_q;
      if (wr_en && full_q) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wbin_q  <= '0;
         wptr_q  <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wptr_q  <= wptr_d;
         full_q  <= full_d;
         afull_q <= afull_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign wptr        = wptr_q;
   assign waddr       = wbin_q[WIDTH-1:0];
   assign full        = full_q;
   assign almost_full = afull_q;
   assign wr_count    = count_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - randomized self-checking bench for fifo_wr_ctrl against an occupancy-based model
module tb_fifo_wr_ctrl;

   logic       clk;
   logic       rstn;
   logic       wr_en;
   logic       ovf_clr;
   logic [3:0] rptr_sync;
   logic [3:0] wptr;
   logic [2:0] waddr;
   logic       wr_accept;
   logic       full;
   logic       almost_full;
   logic [3:0] wr_count;
   logic       overflow;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: binary write count mod 16, read position, derived flags.
   int m_wbin = 0;
   int rd_bin = 0;
   bit m_full = 0;
   bit m_af   = 0;
   int m_cnt  = 0;
   bit m_ovf  = 0;

   fifo_wr_ctrl #(.WIDTH(3), .AFULL_THRESH(6)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .wr_en       (wr_en),
      .ovf_clr     (ovf_clr),
      .rptr_sync   (rptr_sync),
      .wptr        (wptr),
      .waddr       (waddr),
      .wr_accept   (wr_accept),
      .full        (full),
      .almost_full (almost_full),
      .wr_count    (wr_count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] to_gray(input int b);
      logic [3:0] x;
      x = b[3:0];
      return x ^ (x >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
   task automatic cycle(input bit we, input bit oc, input int rd);
      bit         acc;
      int         occ;
      logic [3:0] prev;
      wr_en     = we;
      ovf_clr   = oc;
      rd_bin    = rd;
      rptr_sync = to_gray(rd);
      #1;
      acc = we && !m_full;
      check("wr_accept", wr_accept, acc);
      check("waddr", waddr, m_wbin % 8);
      check("acc_while_full", wr_accept & full, 0);
      prev = wptr;
      @(posedge clk);
      if (acc) m_wbin = (m_wbin + 1) % 16;
      occ    = (m_wbin - rd + 32) % 16;
      m_full = (occ == 8);
      m_cnt  = occ;
      m_af   = (occ >= 6);
      if (we && !acc) m_ovf = 1;
      else if (oc)    m_ovf = 0;
      #1;
      check("wptr", wptr, to_gray(m_wbin));
      check("full", full, m_full);
      check("wr_count", wr_count, m_cnt);
      check("almost_full", almost_full, m_af);
      check("overflow", overflow, m_ovf);
      if (acc) check("gray_step", $countones(prev ^ wptr), 1);
      else     check("gray_hold", wptr, prev);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wptr"}, wptr, 0);
      check({tag, "_waddr"}, waddr, 0);
      check({tag, "_wr_accept"}, wr_accept, 0);
      check({tag, "_full"}, full, 0);
      check({tag, "_afull"}, almost_full, 0);
      check({tag, "_count"}, wr_count, 0);
      check({tag, "_ovf"}, overflow, 0);
   endtask

   initial begin
      logic [3:0] t2_exp [8];
      bit         saw8;
      bit         wrapped;
      int         occ;
      int         k;
      t2_exp = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};

      rstn      = 1'b0;
      wr_en     = 1'b0;
      ovf_clr   = 1'b0;
      rptr_sync = 4'd0;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;

      // T2 fill
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, 0);
         check("t2_wptr", wptr, t2_exp[i]);
         if (i == 4) check("t2_afull_before", almost_full, 0);
         if (i == 5) begin
            check("t2_afull_at6", almost_full, 1);
            check("t2_count6", wr_count, 6);
         end
         if (i == 6) check("t2_not_full7", full, 0);
      end
      check("t2_full", full, 1);
      check("t2_count8", wr_count, 8);

      // T3 overflow
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      check("t3_wptr_hold", wptr, 12);
      check("t3_ovf", overflow, 1);
      cycle(1, 1, 0);
      check("t3_ovf_set_wins", overflow, 1);
      cycle(0, 1, 0);
      check("t3_ovf_clr", overflow, 0);

      // T4 drain
      cycle(0, 0, 3);
      check("t4_full", full, 0);
      check("t4_count", wr_count, 5);
      check("t4_afull", almost_full, 0);

      // T5 wrap with the reader close behind
      saw8 = 0;
      wrapped = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(1, 0, (m_wbin + 15) % 16);
         check("t5_count", wr_count, 2);
         check("t5_full", full, 0);
         if (saw8 && wptr == 4'd0) wrapped = 1;
         saw8 = (wptr == 4'd8);
      end
      check("t5_wrapped", wrapped, 1);

      // T6 random traffic with a monotonic reader
      for (int i = 0; i < 400; i++) begin
         occ = (m_wbin - rd_bin + 16) % 16;
         k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, occ) : 0;
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, (rd_bin + k) % 16);
      end

      // T1 asynchronous reset mid-stream
      cycle(1, 0, rd_bin);
      wr_en = 1'b1;
      rstn  = 1'b0;
      #1;
      check_all_zero("t1_async");
      repeat (2) begin
         @(posedge clk);
         #1;
         check_all_zero("t1_held");
      end
      rstn = 1'b1;
      m_wbin = 0;
      m_full = 0;
      m_af   = 0;
      m_cnt  = 0;
      m_ovf  = 0;
      cycle(1, 0, 0);
      check("t1_resume_wptr", wptr, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
